// File: rtl/i2c_tx_ser_if.sv
// Bus bundle between the I2C slave-transmit serializer and its environment.
// The slave modport is the serializer side; the master modport is the byte source / line front end.
interface i2c_tx_ser_if #(
  parameter int FRAME_BYTES = 4
);
  localparam int CTR_W = $clog2(FRAME_BYTES + 1);

  logic             start_in;
  logic             stop_in;
  logic             scl_rise_in;
  logic             scl_fall_in;
  logic             sda_in;
  logic [7:0]       data_in;
  logic             valid_in;
  logic             ready_out;
  logic             sda_oe_out;
  logic             busy_out;
  logic             done_out;
  logic             nack_out;
  logic             underrun_out;
  logic [CTR_W-1:0] bytectr_out;

  modport slave (
    input  start_in, stop_in, scl_rise_in, scl_fall_in, sda_in, data_in, valid_in,
    output ready_out, sda_oe_out, busy_out, done_out, nack_out, underrun_out, bytectr_out
  );

  modport master (
    output start_in, stop_in, scl_rise_in, scl_fall_in, sda_in, data_in, valid_in,
    input  ready_out, sda_oe_out, busy_out, done_out, nack_out, underrun_out, bytectr_out
  );
endinterface

// File: rtl/i2c_tx_ser.sv
// I2C slave-transmitter serializer: shifts FRAME_BYTES bytes MSB first onto open-drain SDA.
// Define I2C_TX_ACKCHK_EN to abort the frame on a master NACK; otherwise every byte counts as ACKed.
module i2c_tx_ser #(
  parameter int FRAME_BYTES = 4
) (
  input  logic      clk,
  input  logic      rst,
  i2c_tx_ser_if.slave bus
);
  localparam int               CTR_W     = $clog2(FRAME_BYTES + 1);
  localparam logic [CTR_W-1:0] LAST_BYTE = CTR_W'(FRAME_BYTES);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, ACK} state_t;

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [CTR_W-1:0] bytectr_q, bytectr_d, bytectr_inc;
  logic             sda_oe_q, sda_oe_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;
  logic             rise, fall;
`ifdef I2C_TX_ACKCHK_EN
  logic             ack_q, ack_d;
  logic             nack_q, nack_d;
`endif

  // Coincident edge pulses carry no usable information and are dropped.
  assign rise        = bus.scl_rise_in & ~bus.scl_fall_in;
  assign fall        = bus.scl_fall_in & ~bus.scl_rise_in;
  assign bytectr_inc = bytectr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    bytectr_d  = bytectr_q;
    sda_oe_d   = 1'b0;
    done_d     = 1'b0;
    underrun_d = 1'b0;
`ifdef I2C_TX_ACKCHK_EN
    ack_d      = ack_q;
    nack_d     = 1'b0;
`endif
    if (bus.stop_in) begin
      state_d = IDLE;
    end else if (bus.start_in) begin
      state_d   = LOAD;
      bytectr_d = '0;
    end else begin
      case (state_q)
        IDLE: ;
        LOAD: begin
          if (bus.valid_in) begin
            shift_d  = bus.data_in;
            bitcnt_d = 3'd0;
            state_d  = SHIFT;
          end else if (rise) begin
            // Nothing to send: release SDA for the whole byte.
            underrun_d = 1'b1;
            shift_d    = 8'hFF;
            bitcnt_d   = 3'd0;
            state_d    = SHIFT;
          end
        end
        SHIFT: begin
          sda_oe_d = ~shift_q[7];
          if (fall) begin
            if (bitcnt_q < 3'd7) begin
              shift_d  = {shift_q[6:0], 1'b0};
              bitcnt_d = bitcnt_q + 3'd1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ACK;
`ifdef I2C_TX_ACKCHK_EN
              ack_d    = 1'b0;
`endif
            end
          end
        end
        ACK: begin
          if (rise) begin
`ifdef I2C_TX_ACKCHK_EN
            ack_d = bus.sda_in;
`endif
          end else if (fall) begin
`ifdef I2C_TX_ACKCHK_EN
            if (ack_q) begin
              nack_d  = 1'b1;
              state_d = IDLE;
            end else
`endif
            begin
              bytectr_d = bytectr_inc;
              if (bytectr_inc == LAST_BYTE) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = LOAD;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bitcnt_q   <= 3'd0;
      bytectr_q  <= '0;
      sda_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      bytectr_q  <= bytectr_d;
      sda_oe_q   <= sda_oe_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef I2C_TX_ACKCHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q  <= 1'b0;
      nack_q <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      nack_q <= nack_d;
    end
  end

  assign bus.nack_out = nack_q;
`else
  assign bus.nack_out = 1'b0;
`endif

  assign bus.ready_out    = (state_q == LOAD);
  assign bus.busy_out     = (state_q != IDLE);
  assign bus.sda_oe_out   = sda_oe_q;
  assign bus.done_out     = done_q;
  assign bus.underrun_out = underrun_q;
  assign bus.bytectr_out  = bytectr_q;
endmodule

// File: doc/i2c_tx_ser.md
I2C_TX_SER -- requirements
Module: i2c_tx_ser

Interface
REQ-001 Parameter FRAME_BYTES, default 4, number of data bytes per read frame (range 1..16).
REQ-002 Port clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port start_in  input  1  one-cycle pulse: start or repeated start addressed to us in read mode; SCL is low.
REQ-005 Port stop_in  input  1  one-cycle pulse: I2C stop condition detected.
REQ-006 Port scl_rise_in  input  1  one-cycle pulse on synchronized SCL rising edge.
REQ-007 Port scl_fall_in  input  1  one-cycle pulse on synchronized SCL falling edge.
REQ-008 Port sda_in  input  1  synchronized SDA line level.
REQ-009 Port data_in  input  8  byte to transmit, MSB first.
REQ-010 Port valid_in  input  1  data_in valid.
REQ-011 Port ready_out  output  1  byte accepted when valid_in and ready_out are both high in the same cycle.
REQ-012 Port sda_oe_out  output  1  1 = pull SDA low (open drain); 0 = release.
REQ-013 Port busy_out  output  1  high in every state except IDLE.
REQ-014 Port done_out  output  1  one-cycle pulse: frame completed with all bytes ACKed.
REQ-015 Port nack_out  output  1  one-cycle pulse: master NACKed a byte.
REQ-016 Port underrun_out  output  1  one-cycle pulse: no byte available at first SCL rise of a byte.
REQ-017 Port bytectr_out  output  $clog2(FRAME_BYTES+1)  bytes ACKed in current frame.

Function
REQ-018 FSM states IDLE, LOAD, SHIFT, ACK; encoding free.
REQ-019 IDLE: outputs low; start_in -> LOAD with bytectr 0.
REQ-020 LOAD: ready_out=1, sda_oe_out=0; handshake -> shift register <= data_in, bit counter <= 0 -> SHIFT.
REQ-021 LOAD, scl_rise_in without handshake: underrun_out pulse, shift register <= 8'hFF, bit counter <= 0 -> SHIFT; handshake in the same cycle wins, no underrun.
REQ-022 SHIFT: sda_oe_out = NOT shift register bit 7, registered; new bit valid one cycle after entry or shift.
REQ-023 SHIFT, scl_fall_in: bit counter < 7 -> shift left one and increment; bit counter == 7 -> ACK with sda_oe_out=0.
REQ-024 ACK, scl_rise_in: register sda_in as ack bit (0 = ACK, 1 = NACK).
REQ-025 ACK, scl_fall_in, ack bit 0: bytectr increments; if new value == FRAME_BYTES -> done_out pulse -> IDLE, else -> LOAD.
REQ-026 ACK, scl_fall_in, ack bit 1: nack_out pulse -> IDLE; bytectr holds.
REQ-027 stop_in in any state -> IDLE next cycle, sda_oe_out=0, no done/nack pulse; priority over all other inputs except rst.
REQ-028 start_in while busy (repeated start) -> LOAD, bytectr 0; priority below stop_in only.
REQ-029 scl_rise_in and scl_fall_in high together: both ignored.
REQ-030 bytectr_out holds its value in IDLE until next start_in.

Reset
REQ-031 rst high: state IDLE, shift register 8'h00, counters 0, all outputs 0, immediately without clk.
REQ-032 rst mid-frame: SDA released at once; after release, module waits for start_in.

Configuration
REQ-033 Macro I2C_TX_ACKCHK_EN defined: ACK bit evaluated per REQ-025/026.
REQ-034 Macro I2C_TX_ACKCHK_EN undefined: ack bit treated as 0; frame always runs to FRAME_BYTES; nack_out tied 0.

Verification
REQ-035 start_in, byte 8'hA5 in LOAD, 9 SCL clocks, sda_in=0 at 9th rise -> sda_oe_out on rises 0,1,0,1,1,0,1,0; bytectr_out=1; state LOAD.
REQ-036 4 bytes 8'h01,8'h02,8'h03,8'h04 all ACKed, FRAME_BYTES=4 -> done_out pulse after 36th SCL fall; bytectr_out=4; busy_out=0.
REQ-037 Byte 2 NACKed (sda_in=1 at 18th rise) -> nack_out pulse at 18th fall; bytectr_out=1; IDLE; with macro undefined frame continues to done_out.
REQ-038 valid_in low through first SCL rise in LOAD -> underrun_out pulse; SDA released for 8 bits (8'hFF).
REQ-039 stop_in after 3rd SCL fall of a byte -> IDLE next cycle, sda_oe_out=0, no done/nack pulse.
REQ-040 rst asserted mid-SHIFT with sda_oe_out=1 -> sda_oe_out=0 before next clk edge; all outputs 0.
